rr_arbiter_4: RTL and testbench

- Round-robin arbiter that shares one datapath resource among four requesters.
- Issues a registered one-hot grant plus a 2-bit encoded grant index; the index drives the resource's input/output mux select.
- An owner keeps the grant while its request stays high, up to a bounded hold time. After that it is preempted if any other requester is waiting.
- Sits between the four requesting engines and the shared resource.

---
 rtl/rr_arbiter_4_pkg.sv | 16 +
 rtl/rr_arbiter_4_if.sv | 14 +
 rtl/rr_arbiter_4_pick.sv | 30 +++
 rtl/rr_arbiter_4.sv | 101 ++++++++++
 tb/tb_rr_arbiter_4.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/rr_arbiter_4_pkg.sv
// Shared constants and helpers for the four-way round-robin arbiter.
// State encodings are plain localparams so they can be reused in legacy code.
package rr_arbiter_4_pkg;
   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction
endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the four engines and the arbiter.
// The slave side is the arbiter; the master side drives the requests.
interface rr_arbiter_4_if;
   import rr_arbiter_4_pkg::*;

   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] gnt;
   logic [IDX_W-1:0]   gnt_idx;
   logic               gnt_valid;
   logic               preempt;

   modport master (output req, input gnt, gnt_idx, gnt_valid, preempt);
   modport slave  (input req, output gnt, gnt_idx, gnt_valid, preempt);
endinterface

// File: rtl/rr_arbiter_4_pick.sv
// Combinational round-robin pick: the first requester set, scanning from
// last_idx+1 upward with wrap, wins. last_idx itself is examined last.
module rr_pick_4
   import rr_arbiter_4_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_idx,
   output logic [IDX_W-1:0]   pick_idx,
   output logic               pick_valid
);

   logic [IDX_W-1:0] cand;

   // NOTE: every output gets a default before the loop; otherwise an
   // all-zero req leaves them unassigned and a latch is inferred.
   always_comb begin
      pick_idx   = '0;
      pick_valid = 1'b0;
      cand       = '0;
      // Walk from the farthest offset down so the nearest hit overwrites.
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand = last_idx + IDX_W'(k);
         if (req[cand]) begin
            pick_idx   = cand;
            pick_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with a bounded hold time per owner.
// Grant, index, valid and preempt are all registered on the same edge.
module rr_arbiter_4
   import rr_arbiter_4_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 4
) (
   input logic           clk,
   input logic           rst_n,
   rr_arbiter_4_if.slave bus
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   logic [0:0]         state;
   logic [CNT_W-1:0]   hold_cnt;
   logic [IDX_W-1:0]   last_idx;
   logic [NUM_REQ-1:0] gnt;
   logic [IDX_W-1:0]   gnt_idx;
   logic               gnt_valid;
   logic               preempt;

   logic [IDX_W-1:0]   pick_idx;
   logic               pick_valid;
   logic               owner_req;
   logic               others;
   logic               at_limit;
   logic               take_new;
   logic               timeout;
   logic               go_idle;

   rr_pick_4 u_pick (
      .req        (bus.req),
      .last_idx   (last_idx),
      .pick_idx   (pick_idx),
      .pick_valid (pick_valid)
   );

   always_comb begin
      owner_req = bus.req[last_idx];
      others    = |(bus.req & ~onehot(last_idx));
      at_limit  = (hold_cnt == HOLD_LAST);
      take_new  = 1'b0;
      timeout   = 1'b0;
      go_idle   = 1'b0;
      if (state == ST_IDLE) begin
         take_new = pick_valid;
      end else if (owner_req) begin
         // Owner is only displaced once its hold budget is spent.
         if (at_limit && others) begin
            take_new = 1'b1;
            timeout  = 1'b1;
         end
      end else if (others) begin
         take_new = 1'b1;
      end else begin
         go_idle = 1'b1;
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // sees pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         hold_cnt  <= '0;
         last_idx  <= IDX_W'(NUM_REQ - 1);
         gnt       <= '0;
         gnt_idx   <= '0;
         gnt_valid <= 1'b0;
         preempt   <= 1'b0;
      end else if (take_new) begin
         state     <= ST_BUSY;
         hold_cnt  <= '0;
         last_idx  <= pick_idx;
         gnt       <= onehot(pick_idx);
         gnt_idx   <= pick_idx;
         gnt_valid <= 1'b1;
         preempt   <= timeout;
      end else if (go_idle) begin
         state     <= ST_IDLE;
         hold_cnt  <= '0;
         gnt       <= '0;
         gnt_idx   <= '0;
         gnt_valid <= 1'b0;
         preempt   <= 1'b0;
      end else begin
         preempt <= 1'b0;
         if (state == ST_BUSY && !at_limit) begin
            hold_cnt <= hold_cnt + 1'b1;
         end
      end
   end

   assign bus.gnt       = gnt;
   assign bus.gnt_idx   = gnt_idx;
   assign bus.gnt_valid = gnt_valid;
   assign bus.preempt   = preempt;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4 (MAX_HOLD=4): a behavioural model
// pushes expected outputs per cycle, popped and compared after each edge.
module tb_rr_arbiter_4;

   localparam int MAX_HOLD = 4;

   typedef struct {
      logic [3:0] gnt;
      logic [1:0] idx;
      logic       valid;
      logic       preempt;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;

   rr_arbiter_4_if bus ();

   rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];

   // Model state: current owner (-1 idle), last winner, cycles held so far.
   int   m_owner = -1;
   int   m_last  = 3;
   int   m_held  = 0;
   logic m_pre   = 1'b0;

   // Observed values and sticky counters for the directed checks.
   logic [3:0] obs_gnt;
   logic [1:0] obs_idx;
   logic       obs_valid;
   logic       obs_pre;
   int         pre_cnt;
   int         vlow_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int rr(input logic [3:0] r, input int last);
      for (int k = 1; k <= 4; k++) begin
         if (r[(last + k) % 4]) return (last + k) % 4;
      end
      return -1;
   endfunction

   task automatic model_step(input logic [3:0] r, input logic rn);
      logic others;
      int   p;
      if (!rn) begin
         m_owner = -1; m_last = 3; m_held = 0; m_pre = 1'b0;
      end else if (m_owner < 0) begin
         p     = rr(r, m_last);
         m_pre = 1'b0;
         if (p >= 0) begin
            m_owner = p; m_last = p; m_held = 1;
         end
      end else begin
         others = (r & ~(4'b0001 << m_owner)) != 4'b0000;
         if (r[m_owner] && !(m_held >= MAX_HOLD && others)) begin
            m_held++;
            m_pre = 1'b0;
         end else if (others) begin
            p       = rr(r, m_last);
            m_pre   = r[m_owner];
            m_owner = p; m_last = p; m_held = 1;
         end else begin
            m_owner = -1; m_held = 0; m_pre = 1'b0;
         end
      end
   endtask

   task automatic cycle(input logic [3:0] r, input logic rn);
      exp_t e;
      bus.req = r;
      rst_n   = rn;
      model_step(r, rn);
      e.gnt     = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
      e.idx     = (m_owner < 0) ? 2'd0 : 2'(m_owner);
      e.valid   = (m_owner >= 0);
      e.preempt = m_pre;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e         = exp_q.pop_front();
      obs_gnt   = bus.gnt;
      obs_idx   = bus.gnt_idx;
      obs_valid = bus.gnt_valid;
      obs_pre   = bus.preempt;
      if (obs_pre)    pre_cnt++;
      if (!obs_valid) vlow_cnt++;
      check("gnt",       32'(obs_gnt),   32'(e.gnt));
      check("gnt_idx",   32'(obs_idx),   32'(e.idx));
      check("gnt_valid", 32'(obs_valid), 32'(e.valid));
      check("preempt",   32'(obs_pre),   32'(e.preempt));
   endtask

   initial begin
      rst_n   = 1'b0;
      bus.req = 4'b0000;

      // Reset with all requesting, then release.
      cycle(4'b1111, 1'b0);
      cycle(4'b1111, 1'b0);
      check("rst_gnt", 32'(obs_gnt), 32'h0);
      check("rst_valid", 32'(obs_valid), 32'h0);
      pre_cnt = 0;
      cycle(4'b1111, 1'b1);
      check("first_gnt", 32'(obs_gnt), 32'h1);

      // Timeout rotation 0,1,2,3,0 with 4 cycles each.
      for (int i = 0; i < 16; i++) begin
         cycle(4'b1111, 1'b1);
         if (i == 3)  check("rot_to_1", 32'(obs_gnt), 32'h2);
         if (i == 11) check("rot_to_3", 32'(obs_gnt), 32'h8);
      end
      check("rot_back_0", 32'(obs_gnt), 32'h1);
      check("rot_preempts", 32'(pre_cnt), 32'd4);

      // Release handoff from owner 0 to owner 2 with no idle bubble.
      cycle(4'b0101, 1'b0);
      vlow_cnt = 0;
      cycle(4'b0101, 1'b1);
      cycle(4'b0101, 1'b1);
      cycle(4'b0100, 1'b1);
      check("handoff_gnt", 32'(obs_gnt), 32'h4);
      check("handoff_pre", 32'(obs_pre), 32'h0);
      check("handoff_vlow", 32'(vlow_cnt), 32'd0);

      // Lone requester holds indefinitely, then is preempted at once.
      pre_cnt = 0;
      for (int i = 0; i < 20; i++) cycle(4'b1000, 1'b1);
      check("lone_gnt", 32'(obs_gnt), 32'h8);
      check("lone_nopre", 32'(pre_cnt), 32'd0);
      cycle(4'b1010, 1'b1);
      check("lone_pre_gnt", 32'(obs_gnt), 32'h2);
      check("lone_pre", 32'(obs_pre), 32'h1);

      // Reset mid-grant drops the grant and restores priority to 0.
      cycle(4'b1111, 1'b0);
      check("midrst_gnt", 32'(obs_gnt), 32'h0);
      cycle(4'b1111, 1'b1);
      check("midrst_next", 32'(obs_gnt), 32'h1);

      // Idle from owner 2, then re-arm continues rotation after 2.
      cycle(4'b0100, 1'b1);
      cycle(4'b0000, 1'b1);
      check("idle_gnt", 32'(obs_gnt), 32'h0);
      check("idle_valid", 32'(obs_valid), 32'h0);
      cycle(4'b0101, 1'b1);
      check("rearm_gnt", 32'(obs_gnt), 32'h1);

      // Random traffic with occasional resets, checked against the model.
      for (int i = 0; i < 300; i++) begin
         cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 31) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
